// File: rtl/icache_types.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_types;

  localparam int S_INDEX_DEF  = 4;
  localparam int S_OFFSET_DEF = 5;
  localparam int TAG_W_DEF    = 32 - S_INDEX_DEF - S_OFFSET_DEF;
  localparam int LINE_W       = 256;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the icache: asynchronous read, write on fill,
// valid bits cleared by asynchronous reset (tag/data need no reset).
module icache_array
  import icache_types::*;
#(
  parameter int S_INDEX = S_INDEX_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [S_INDEX-1:0] widx_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  line_t              wdata_i,
  input  logic [S_INDEX-1:0] ridx_i,
  output logic               rvalid_o,
  output logic [TAG_W-1:0]   rtag_o,
  output line_t              rdata_o
);

  localparam int SETS = 2 ** S_INDEX;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  line_t            data_q [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with zero-cycle hits and one
// outstanding line fill. Optional hit/miss counters under ICACHE_PERF_EN.
module icache
  import icache_types::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic        inst_resp,
  output logic [31:0] inst_rdata,
  output logic        pmem_read,
  output logic [31:0] pmem_address,
  input  logic        pmem_resp,
  input  line_t       pmem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_W = 32 - S_INDEX - S_OFFSET;

  state_e                state_q, state_d;
  logic [31-S_OFFSET:0]  line_q, line_d;

  logic [TAG_W-1:0]      req_tag;
  logic [S_INDEX-1:0]    req_idx;
  logic [S_OFFSET-3:0]   word_sel;
  logic                  arr_valid;
  logic [TAG_W-1:0]      arr_tag;
  line_t                 arr_line;
  logic                  hit;
  logic                  fill_we;
  logic                  hit_ev;
  logic                  miss_ev;
  logic                  unused_addr_bits;

  assign req_tag          = inst_addr[31:S_OFFSET+S_INDEX];
  assign req_idx          = inst_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign word_sel         = inst_addr[S_OFFSET-1:2];
  assign unused_addr_bits = ^inst_addr[1:0];

  icache_array #(
    .S_INDEX (S_INDEX),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we_i     (fill_we),
    .widx_i   (line_q[S_INDEX-1:0]),
    .wtag_i   (line_q[31-S_OFFSET:S_INDEX]),
    .wdata_i  (pmem_rdata),
    .ridx_i   (req_idx),
    .rvalid_o (arr_valid),
    .rtag_o   (arr_tag),
    .rdata_o  (arr_line)
  );

  assign hit = arr_valid && (arr_tag == req_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    inst_resp    = 1'b0;
    inst_rdata   = '0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    fill_we      = 1'b0;
    hit_ev       = 1'b0;
    miss_ev      = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_read) begin
          if (hit) begin
            inst_resp  = 1'b1;
            inst_rdata = arr_line[{word_sel, 5'b0} +: 32];
            hit_ev     = 1'b1;
          end else begin
            line_d  = inst_addr[31:S_OFFSET];
            state_d = FETCH;
            miss_ev = 1'b1;
          end
        end
      end
      FETCH: begin
        // Address comes only from the latched line so CPU address changes are ignored.
        pmem_read    = 1'b1;
        pmem_address = {line_q, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          fill_we = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ev)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_ev) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = hit_ev ^ miss_ev;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed scenarios plus random fetches checked
// against a set/tag model and a hashed backing memory.
module tb_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inst_read = 1'b0;
  logic [31:0]  inst_addr = '0;
  logic         inst_resp;
  logic [31:0]  inst_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic         pmem_resp = 1'b0;
  logic [255:0] pmem_rdata = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_resp    (inst_resp),
    .inst_rdata   (inst_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          mem_delay = 0;
  logic [31:0] exp_q[$];
  bit          mvalid[16];
  logic [22:0] mtag[16];
  logic [31:0] mem_a;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_006C) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(base + 32'(4 * i));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // Monitor: every response consumes exactly one queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      chk("resp_with_pmem_read", 32'(inst_resp & pmem_read), 32'd0);
      if (inst_resp) begin
        chk("queue_depth_at_resp", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) chk("inst_rdata", inst_rdata, exp_q.pop_front());
      end else begin
        chk("rdata_zero_without_resp", inst_rdata, 32'd0);
      end
    end
  end

  // Backing memory: answers after mem_delay cycles with a one-cycle pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (pmem_read === 1'b1) begin
        mem_a = pmem_address;
        repeat (mem_delay) @(negedge clk);
        pmem_rdata = mem_line(mem_a);
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    inst_read = 1'b0;
    #1;
    chk("reset_inst_resp", 32'(inst_resp), 32'd0);
    chk("reset_inst_rdata", inst_rdata, 32'd0);
    chk("reset_pmem_read", 32'(pmem_read), 32'd0);
    chk("reset_pmem_address", pmem_address, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask

  task automatic fetch(input logic [31:0] a, input bit toggle);
    int          idx = int'(a[8:5]);
    logic [22:0] tg = a[31:9];
    bit          hit = mvalid[idx] && (mtag[idx] == tg);
    int          d = mem_delay;
    int          cyc = 0;
    bit          got = 1'b0;
    exp_q.push_back(mem_word(a));
    @(posedge clk);
    #1;
    inst_read = 1'b1;
    inst_addr = a;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (inst_resp) begin
        got = 1'b1;
      end else begin
        cyc++;
        if (pmem_read) chk("pmem_address", pmem_address, a & 32'hFFFF_FFE0);
        if (toggle && cyc == 2) inst_addr = 32'h0000_1000;
        if (toggle && cyc == 6) inst_addr = a;
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    if (hit) chk("hit_latency", 32'(cyc), 32'd0);
    else     chk("miss_latency", 32'(cyc), 32'(3 + d));
    if (!got) exp_q.delete();
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    @(posedge clk);
    #1;
    inst_read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    clear_model();
    do_reset();

    mem_delay = 0;
    fetch(32'h0000_006C, 1'b0);
    fetch(32'h0000_0064, 1'b0);
`ifdef ICACHE_PERF_EN
    // The miss fetch also completes with one hit cycle after its fill.
    chk("hit_count", hit_count, 32'd2);
    chk("miss_count", miss_count, 32'd1);
`endif

    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0200, 1'b0);
    fetch(32'h0000_0000, 1'b0);

    do_reset();
    mem_delay = 10;
    fetch(32'h0000_0068, 1'b1);
    mem_delay = 0;
    fetch(32'h0000_1000, 1'b0);
    fetch(32'h0000_0060, 1'b0);

    do_reset();
    mem_delay = 10;
    @(posedge clk);
    #1;
    inst_read = 1'b1;
    inst_addr = 32'h0000_0060;
    @(negedge clk);
    @(negedge clk);
    chk("fetch_pmem_read", 32'(pmem_read), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_pmem_read", 32'(pmem_read), 32'd0);
    chk("abort_pmem_address", pmem_address, 32'd0);
    chk("abort_inst_resp", 32'(inst_resp), 32'd0);
    inst_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_model();
    repeat (20) @(negedge clk);
    mem_delay = 0;
    fetch(32'h0000_0060, 1'b0);

    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      mem_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        inst_addr = $urandom;
        repeat (2) begin
          @(negedge clk);
          chk("idle_no_pmem_read", 32'(pmem_read), 32'd0);
        end
      end
      fetch(a, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
